// File: rtl/tb_survivor_mem.sv
// ============================================================================
//  Module   : tb_survivor_mem
//  Purpose  : Survivor-path memory for the Viterbi decoder. One predecessor-
//             state vector per trellis stage is written into a two-bank
//             ping-pong store. Each filled bank is replayed newest-to-oldest
//             under valid/ready while the other bank keeps filling.
//  Ports    : clk, rst            - clock, async active-high reset
//             i_en, i_fwd_prv_st  - write strobe and forward vector
//             i_flush             - synchronous clear of pointers and FSM
//             i_rdy               - downstream ready
//             o_bck_prv_st, o_vld - replayed vector and its valid
//             o_first, o_last     - newest / oldest stage of a block
//             o_sync              - sticky, first bank handed to reader
//             o_ovf               - one-cycle pulse, filled bank discarded
//             o_perr              - parity error on the presented beat
//  Options  : define TB_SURV_PARITY_EN to store and check a per-row even
//             parity bit; otherwise o_perr is tied low.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_survivor_mem #(
    parameter int ST_NUM   = 64,
    parameter int ST_W     = 6,
    parameter int TB_DEPTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_en,
    input  logic [ST_NUM*ST_W-1:0]   i_fwd_prv_st,
    input  logic                     i_flush,
    input  logic                     i_rdy,
    output logic [ST_NUM*ST_W-1:0]   o_bck_prv_st,
    output logic                     o_vld,
    output logic                     o_first,
    output logic                     o_last,
    output logic                     o_sync,
    output logic                     o_ovf,
    output logic                     o_perr
);

    localparam int c_VEC_W = ST_NUM * ST_W;
    localparam int c_AW    = (TB_DEPTH > 1) ? $clog2(TB_DEPTH) : 1;
    localparam logic [c_AW-1:0] c_LAST_ADDR = c_AW'(TB_DEPTH - 1);
    localparam logic [c_AW-1:0] c_ZERO_ADDR = '0;

`ifdef TB_SURV_PARITY_EN
    localparam int c_ROW_W = c_VEC_W + 1;   // parity bit sits in the MSB
`else
    localparam int c_ROW_W = c_VEC_W;
`endif

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RD   = 1'b1
    } rd_state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [c_ROW_W-1:0] r_mem [2][TB_DEPTH];

    logic               r_wr_bank;
    logic [c_AW-1:0]    r_wr_addr;
    logic               r_rd_bank;
    logic [c_AW-1:0]    r_rd_addr;
    rd_state_t          r_state;
    rd_state_t          w_state_nxt;

    logic [c_VEC_W-1:0] r_data;
    logic               r_vld;
    logic               r_first;
    logic               r_last;
    logic               r_sync;
    logic               r_ovf;

    logic               w_advance;
    logic               w_issue;
    logic               w_bank_full;
    logic               w_rd_free;
    logic               w_handover;
    logic               w_ovf;
    logic [c_ROW_W-1:0] w_wr_row;
    logic [c_ROW_W-1:0] w_rd_row;

    // ------------------------------------------------------------------
    // Handshake and handover decode
    // ------------------------------------------------------------------
    // The output register doubles as the read-data register, so the read
    // pipeline moves only when that register is empty or being consumed.
    assign w_advance   = !r_vld || i_rdy;
    assign w_issue     = (r_state == S_RD) && w_advance;
    assign w_bank_full = i_en && (r_wr_addr == c_LAST_ADDR);
    // The reader can take a new bank when idle, or when it is issuing the
    // oldest row of its current bank this very cycle (gapless streaming).
    assign w_rd_free   = (r_state == S_IDLE) || (w_issue && (r_rd_addr == c_ZERO_ADDR));
    assign w_handover  = w_bank_full && w_rd_free;
    assign w_ovf       = w_bank_full && !w_rd_free;

`ifdef TB_SURV_PARITY_EN
    assign w_wr_row = {^i_fwd_prv_st, i_fwd_prv_st};
`else
    assign w_wr_row = i_fwd_prv_st;
`endif

    assign w_rd_row = r_mem[r_rd_bank][r_rd_addr];

    // ------------------------------------------------------------------
    // Storage (contents are don't-care after reset, so no reset here)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (i_en && !i_flush) begin
            r_mem[r_wr_bank][r_wr_addr] <= w_wr_row;
        end
    end

    // ------------------------------------------------------------------
    // Write pointer, bank toggle, sync and overflow flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_bank <= 1'b0;
            r_wr_addr <= '0;
            r_sync    <= 1'b0;
            r_ovf     <= 1'b0;
        end else if (i_flush) begin
            r_wr_bank <= 1'b0;
            r_wr_addr <= '0;
            r_sync    <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_ovf <= w_ovf;
            if (i_en) begin
                if (w_bank_full) begin
                    r_wr_addr <= '0;
                    // On overflow the bank is kept, so the next block
                    // overwrites the one that could not be handed over.
                    if (w_rd_free) begin
                        r_wr_bank <= ~r_wr_bank;
                        r_sync    <= 1'b1;
                    end
                end else begin
                    r_wr_addr <= r_wr_addr + c_AW'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_rd_bank <= 1'b0;
            r_rd_addr <= '0;
        end else if (i_flush) begin
            r_state   <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
            if (w_handover) begin
                r_rd_bank <= r_wr_bank;
                r_rd_addr <= c_LAST_ADDR;
            end else if (w_issue) begin
                r_rd_addr <= r_rd_addr - c_AW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Read FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: w_state_nxt = S_IDLE;
            S_RD: begin
                if (w_issue && (r_rd_addr == c_ZERO_ADDR)) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // A handover always wins, including on the oldest-row issue cycle.
        if (w_handover) begin
            w_state_nxt = S_RD;
        end
    end

    // ------------------------------------------------------------------
    // Output / read-data register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data  <= '0;
            r_vld   <= 1'b0;
            r_first <= 1'b0;
            r_last  <= 1'b0;
        end else if (i_flush) begin
            r_vld   <= 1'b0;
            r_first <= 1'b0;
            r_last  <= 1'b0;
        end else if (w_advance) begin
            r_vld   <= w_issue;
            r_first <= w_issue && (r_rd_addr == c_LAST_ADDR);
            r_last  <= w_issue && (r_rd_addr == c_ZERO_ADDR);
            if (w_issue) begin
                r_data <= w_rd_row[c_VEC_W-1:0];
            end
        end
    end

`ifdef TB_SURV_PARITY_EN
    logic r_perr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perr <= 1'b0;
        end else if (i_flush) begin
            r_perr <= 1'b0;
        end else if (w_advance) begin
            // Stored bit makes the row even; any odd total is an error.
            r_perr <= w_issue && (^w_rd_row);
        end
    end

    assign o_perr = r_perr;
`else
    assign o_perr = 1'b0;
`endif

    assign o_bck_prv_st = r_data;
    assign o_vld        = r_vld;
    assign o_first      = r_first;
    assign o_last       = r_last;
    assign o_sync       = r_sync;
    assign o_ovf        = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_tb_survivor_mem.sv
`default_nettype none

module tb_tb_survivor_mem;

    localparam int ST_NUM   = 64;
    localparam int ST_W     = 6;
    localparam int TB_DEPTH = 32;
    localparam int VW       = ST_NUM * ST_W;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_en = 1'b0;
    logic          i_flush = 1'b0;
    logic          i_rdy = 1'b0;
    logic [VW-1:0] i_fwd_prv_st = '0;
    logic [VW-1:0] o_bck_prv_st;
    logic          o_vld, o_first, o_last, o_sync, o_ovf, o_perr;

    tb_survivor_mem #(
        .ST_NUM   (ST_NUM),
        .ST_W     (ST_W),
        .TB_DEPTH (TB_DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_en         (i_en),
        .i_fwd_prv_st (i_fwd_prv_st),
        .i_flush      (i_flush),
        .i_rdy        (i_rdy),
        .o_bck_prv_st (o_bck_prv_st),
        .o_vld        (o_vld),
        .o_first      (o_first),
        .o_last       (o_last),
        .o_sync       (o_sync),
        .o_ovf        (o_ovf),
        .o_perr       (o_perr)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Scoreboard bookkeeping
    // ------------------------------------------------------------------
    typedef struct {
        logic [VW-1:0] data;
        logic          first;
        logic          last;
        logic          perr;
        int            addr;
    } beat_t;

    beat_t rdq[$];    // rows of the bank currently being replayed
    beat_t expq[$];   // beats issued, awaiting the monitor

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: banks as plain arrays; a handover snapshots the
    // filled bank as a newest-first list of beats.
    // ------------------------------------------------------------------
    logic [VW-1:0] mem [2][TB_DEPTH];
    int    wbank = 0, waddr = 0, rdbank = 0;
    bit    m_vld = 0, m_sync = 0, m_ovf = 0;
    bit    m_adv, m_iss, m_free;
    beat_t m_b;

    always @(posedge clk or posedge rst) begin
        if (rst || i_flush) begin
            wbank = 0; waddr = 0;
            rdq.delete(); expq.delete();
            m_vld = 0; m_sync = 0; m_ovf = 0;
        end else begin
            m_adv  = !m_vld || i_rdy;
            m_iss  = m_adv && (rdq.size() > 0);
            m_free = (rdq.size() == 0) || (m_iss && rdq.size() == 1);
            if (m_adv) begin
                if (m_iss) begin
                    m_b = rdq.pop_front();
                    expq.push_back(m_b);
                end
                m_vld = m_iss;
            end
            m_ovf = 0;
            if (i_en) begin
                mem[wbank][waddr] = i_fwd_prv_st;
                if (waddr == TB_DEPTH - 1) begin
                    waddr = 0;
                    if (m_free) begin
                        for (int a = TB_DEPTH - 1; a >= 0; a--) begin
                            m_b.data  = mem[wbank][a];
                            m_b.first = (a == TB_DEPTH - 1);
                            m_b.last  = (a == 0);
                            m_b.perr  = 1'b0;
                            m_b.addr  = a;
                            rdq.push_back(m_b);
                        end
                        rdbank = wbank;
                        wbank  = 1 - wbank;
                        m_sync = 1;
                    end else begin
                        m_ovf = 1;
                    end
                end else begin
                    waddr++;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Monitor: a beat is new when the previous sample was empty or taken;
    // otherwise it is a stalled beat and must still match the same entry.
    // ------------------------------------------------------------------
    bit    p_vld = 0, p_rdy = 0;
    beat_t cur;

    always @(negedge clk) begin
        if (rst) begin
            p_vld = 0;
            p_rdy = 0;
        end else begin
            chk("o_vld",  VW'(o_vld),  VW'(m_vld));
            chk("o_sync", VW'(o_sync), VW'(m_sync));
            chk("o_ovf",  VW'(o_ovf),  VW'(m_ovf));
`ifndef TB_SURV_PARITY_EN
            chk("o_perr", VW'(o_perr), VW'(1'b0));
`endif
            if (o_vld) begin
                if (!p_vld || p_rdy) begin
                    if (expq.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL beat_unexpected: got a beat, expected none at %0t", $time);
                        cur.data = 'x; cur.first = 1'bx; cur.last = 1'bx; cur.perr = 1'bx;
                    end else begin
                        cur = expq.pop_front();
                    end
                end
                chk("data",    o_bck_prv_st, cur.data);
                chk("o_first", VW'(o_first), VW'(cur.first));
                chk("o_last",  VW'(o_last),  VW'(cur.last));
`ifdef TB_SURV_PARITY_EN
                chk("o_perr",  VW'(o_perr),  VW'(cur.perr));
`endif
            end
            p_vld = o_vld;
            p_rdy = i_rdy;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    int stage_cnt = 0;

    // Random vector whose state-0 pointer carries the running stage index.
    function automatic logic [VW-1:0] gen_vec(input int k);
        logic [VW-1:0] v;
        for (int i = 0; i < VW / 32; i++) v[i*32 +: 32] = $urandom;
        v[ST_W-1:0] = k[ST_W-1:0];
        return v;
    endfunction

    task automatic run(input int n, input int en_pct, input int rdy_pct);
        for (int c = 0; c < n; c++) begin
            i_en  = (($urandom % 100) < en_pct);
            i_rdy = (($urandom % 100) < rdy_pct);
            if (i_en) begin
                i_fwd_prv_st = gen_vec(stage_cnt);
                stage_cnt++;
            end
            @(posedge clk);
            #1;
        end
        i_en = 1'b0;
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_vld"},   VW'(o_vld),   VW'(1'b0));
        chk({tag, "_first"}, VW'(o_first), VW'(1'b0));
        chk({tag, "_last"},  VW'(o_last),  VW'(1'b0));
        chk({tag, "_sync"},  VW'(o_sync),  VW'(1'b0));
        chk({tag, "_ovf"},   VW'(o_ovf),   VW'(1'b0));
        chk({tag, "_perr"},  VW'(o_perr),  VW'(1'b0));
        chk({tag, "_data"},  o_bck_prv_st, '0);
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_cleared("reset");
        rst = 1'b0;

        // Single block, then drain
        stage_cnt = 0;
        run(TB_DEPTH, 100, 100);
        run(40, 0, 100);

        // Continuous streaming: four blocks back to back
        run(4 * TB_DEPTH, 100, 100);
        run(40, 0, 100);

        // Backpressure in the middle of a block
        run(TB_DEPTH, 100, 100);
        run(3, 0, 100);
        run(10, 0, 0);
        run(40, 0, 100);

        // Overflow: reader stalled while two full blocks arrive
        run(2 * TB_DEPTH, 100, 0);
        run(40, 0, 100);
        run(TB_DEPTH, 100, 100);
        run(40, 0, 100);

        // Flush mid-read, then a fresh block
        run(TB_DEPTH, 100, 100);
        run(11, 0, 100);
        i_flush = 1'b1;
        @(posedge clk);
        #1;
        i_flush = 1'b0;
        run(5, 0, 100);
        run(TB_DEPTH, 100, 100);
        run(40, 0, 100);

        // Asynchronous reset between edges mid-read
        run(TB_DEPTH, 100, 100);
        run(11, 0, 100);
        #2;
        rst = 1'b1;
        #1;
        check_cleared("async_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        run(TB_DEPTH, 100, 100);
        run(40, 0, 100);

        // Random traffic with occasional flushes
        for (int c = 0; c < 800; c++) begin
            i_flush = (($urandom % 250) == 0);
            run(1, 70, 70);
            i_flush = 1'b0;
        end
        run(80, 0, 100);

`ifdef TB_SURV_PARITY_EN
        // Corrupt one stored row of the bank just handed to the reader
        run(TB_DEPTH, 100, 0);
        dut.r_mem[rdbank][5][0] = ~dut.r_mem[rdbank][5][0];
        foreach (rdq[i]) begin
            if (rdq[i].addr == 5) begin
                rdq[i].data[0] = ~rdq[i].data[0];
                rdq[i].perr    = 1'b1;
            end
        end
        run(60, 0, 100);
`endif

        chk("expq_drained", VW'(expq.size()), '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
